// File: rtl/fpnew_pkg.sv
// fpnew_pkg: pipeline split configuration, div/sqrt control FSM states and stage-count helpers.
package fpnew_pkg;
  typedef enum logic [1:0] {BEFORE, AFTER, INSIDE, DISTRIBUTED} pipe_config_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, BUSY = 2'd2, DONE = 2'd3} divsqrt_state_e;
  function automatic int unsigned num_inp_regs(pipe_config_t cfg, int unsigned n);
    return cfg == BEFORE ? n : cfg == DISTRIBUTED ? n / 2 : 0;
  endfunction
  function automatic int unsigned num_out_regs(pipe_config_t cfg, int unsigned n);
    return cfg == BEFORE ? 0 : cfg == DISTRIBUTED ? (n + 1) / 2 : n;
  endfunction
endpackage

// File: rtl/fpnew_divsqrt_ctrl_stage.sv
// fpnew_divsqrt_ctrl_stage: one valid/ready pipeline stage carrying tag and aux.
module fpnew_divsqrt_ctrl_stage #(
  parameter int unsigned TagWidth = 1,
  parameter int unsigned AuxWidth = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [TagWidth-1:0] in_tag_i,
  input  logic [AuxWidth-1:0] in_aux_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [TagWidth-1:0] out_tag_o,
  output logic [AuxWidth-1:0] out_aux_o,
  output logic                load_o
);
  logic valid_q, valid_d;
  logic [TagWidth-1:0] tag_q, tag_d;
  logic [AuxWidth-1:0] aux_q, aux_d;
  always_comb begin
    in_ready_o = ~valid_q | out_ready_i;
    load_o = in_valid_i & in_ready_o & ~flush_i;
    valid_d = flush_i ? 1'b0 : load_o ? 1'b1 : valid_q & ~out_ready_i;
    tag_d = load_o ? in_tag_i : tag_q;
    aux_d = load_o ? in_aux_i : aux_q;
  end
  always_ff @(posedge clk_i) begin
    valid_q <= rst_i ? 1'b0 : valid_d;
    tag_q <= tag_d;
    aux_q <= aux_d;
  end
  assign out_valid_o = valid_q;
  assign out_tag_o = tag_q;
  assign out_aux_o = aux_q;
endmodule

// File: rtl/fpnew_divsqrt_multi_ctrl.sv
// fpnew_divsqrt_multi_ctrl: handshake/pipeline control around an iterative div/sqrt unit.
// Optional BUSY watchdog enabled by defining FPNEW_DIVSQRT_CTRL_WATCHDOG_EN.
module fpnew_divsqrt_multi_ctrl import fpnew_pkg::*; #(
  parameter int unsigned  NumPipeRegs    = 0,
  parameter pipe_config_t PipeConfig     = AFTER,
  parameter int unsigned  TagWidth       = 1,
  parameter int unsigned  AuxWidth       = 1,
  parameter int unsigned  WatchdogCycles = 64
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          in_valid_i,
  output logic                                          in_ready_o,
  input  logic [TagWidth-1:0]                           tag_i,
  input  logic [AuxWidth-1:0]                           aux_i,
  input  logic                                          flush_i,
  output logic                                          out_valid_o,
  input  logic                                          out_ready_i,
  output logic [TagWidth-1:0]                           tag_o,
  output logic [AuxWidth-1:0]                           aux_o,
  output logic                                          busy_o,
  output logic [(NumPipeRegs > 0 ? NumPipeRegs : 1)-1:0] reg_enable_o,
  output logic                                          fsm_start_o,
  input  logic                                          fsm_ready_i,
  output logic                                          error_o
);
  localparam int unsigned NI = num_inp_regs(PipeConfig, NumPipeRegs);
  localparam int unsigned NO = num_out_regs(PipeConfig, NumPipeRegs);
  divsqrt_state_e state_q, state_d;
  logic [TagWidth-1:0] tag_q, tag_d;
  logic [AuxWidth-1:0] aux_q, aux_d;
  logic kill, ready_cond, start, out_load0, wd_hit;
  logic [NI:0] iv, ir;
  logic [TagWidth-1:0] it [0:NI];
  logic [AuxWidth-1:0] ia [0:NI];
  logic [NO:0] ov, orr;
  logic [TagWidth-1:0] ot [0:NO];
  logic [AuxWidth-1:0] oa [0:NO];
  assign kill = flush_i | rst_i;
  assign iv[0] = in_valid_i;
  assign it[0] = tag_i;
  assign ia[0] = aux_i;
  assign in_ready_o = ir[0];
  assign ir[NI] = ready_cond;
  assign ov[0] = state_q == DONE;
  assign ot[0] = tag_q;
  assign oa[0] = aux_q;
  assign orr[NO] = out_ready_i;
  genvar i;
  for (i = 0; i < NI; i++) begin : g_inp
    fpnew_divsqrt_ctrl_stage #(.TagWidth(TagWidth), .AuxWidth(AuxWidth)) u_stage (
      .clk_i, .rst_i, .flush_i(kill),
      .in_valid_i(iv[i]), .in_ready_o(ir[i]), .in_tag_i(it[i]), .in_aux_i(ia[i]),
      .out_valid_o(iv[i+1]), .out_ready_i(ir[i+1]), .out_tag_o(it[i+1]), .out_aux_o(ia[i+1]),
      .load_o(reg_enable_o[i])
    );
  end
  for (i = 0; i < NO; i++) begin : g_out
    fpnew_divsqrt_ctrl_stage #(.TagWidth(TagWidth), .AuxWidth(AuxWidth)) u_stage (
      .clk_i, .rst_i, .flush_i(kill),
      .in_valid_i(ov[i]), .in_ready_o(orr[i]), .in_tag_i(ot[i]), .in_aux_i(oa[i]),
      .out_valid_o(ov[i+1]), .out_ready_i(orr[i+1]), .out_tag_o(ot[i+1]), .out_aux_o(oa[i+1]),
      .load_o(reg_enable_o[NI+i])
    );
  end
  if (NumPipeRegs == 0) begin : g_no_regs
    assign reg_enable_o = '0;
  end
  // A start from DONE is only legal when the finished result leaves in the same cycle.
  always_comb begin
    out_load0 = ov[0] & orr[0] & ~kill;
    ready_cond = fsm_ready_i & (state_q == IDLE | out_load0);
    start = iv[NI] & ready_cond & ~kill;
    state_d = kill ? IDLE : start ? ARM : state_q == ARM ? BUSY :
              state_q == BUSY && fsm_ready_i ? DONE : wd_hit ? IDLE : out_load0 ? IDLE : state_q;
    tag_d = start ? it[NI] : tag_q;
    aux_d = start ? ia[NI] : aux_q;
  end
  always_ff @(posedge clk_i) begin
    state_q <= rst_i ? IDLE : state_d;
    tag_q <= tag_d;
    aux_q <= aux_d;
  end
`ifdef FPNEW_DIVSQRT_CTRL_WATCHDOG_EN
  localparam int unsigned CW = $clog2(WatchdogCycles + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = state_q == ARM ? '0 : state_q == BUSY ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
  assign wd_hit = state_q == BUSY & ~fsm_ready_i & ~kill & cnt_q == CW'(WatchdogCycles - 1);
`else
  assign wd_hit = 1'b0;
`endif
  assign error_o = wd_hit;
  assign fsm_start_o = start;
  assign out_valid_o = ov[NO] & ~rst_i;
  assign tag_o = ot[NO];
  assign aux_o = oa[NO];
  assign busy_o = ~rst_i & ((iv >> 1) != '0 | (ov >> 1) != '0 | state_q != IDLE);
endmodule

// File: tb/tb_fpnew_divsqrt_multi_ctrl.sv
// tb_fpnew_divsqrt_multi_ctrl: directed + randomized scoreboard bench, unpiped and DISTRIBUTED configs.
module tb_fpnew_divsqrt_multi_ctrl;
`ifdef FPNEW_DIVSQRT_CTRL_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, u_mode = 1'b0;
  logic iv0 = 0, ir0, fl0 = 0, ov0, or0 = 0, busy0, st0, fr0_m = 0, fr0, err0;
  logic iv2 = 0, ir2, fl2 = 0, ov2, or2 = 0, busy2, st2, fr2_m = 0, fr2, err2;
  logic [3:0] ti0 = 0, to0, ti2 = 0, to2;
  logic [2:0] ai0 = 0, ao0, ai2 = 0, ao2;
  logic [0:0] re0;
  logic [1:0] re2;
  int ucnt0 = 0, ucnt2 = 0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  assign fr0 = u_mode ? ucnt0 == 0 : fr0_m;
  assign fr2 = u_mode ? ucnt2 == 0 : fr2_m;
  // Behavioural iterative unit: busy for a random 0..5 cycles after each start.
  always @(posedge clk) begin
    ucnt0 <= rst ? 0 : st0 ? int'($urandom_range(0, 5)) : ucnt0 != 0 ? ucnt0 - 1 : 0;
    ucnt2 <= rst ? 0 : st2 ? int'($urandom_range(0, 5)) : ucnt2 != 0 ? ucnt2 - 1 : 0;
  end
  fpnew_divsqrt_multi_ctrl #(.NumPipeRegs(0), .PipeConfig(fpnew_pkg::AFTER), .TagWidth(4),
    .AuxWidth(3), .WatchdogCycles(64)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv0), .in_ready_o(ir0), .tag_i(ti0), .aux_i(ai0),
    .flush_i(fl0), .out_valid_o(ov0), .out_ready_i(or0), .tag_o(to0), .aux_o(ao0),
    .busy_o(busy0), .reg_enable_o(re0), .fsm_start_o(st0), .fsm_ready_i(fr0), .error_o(err0));
  fpnew_divsqrt_multi_ctrl #(.NumPipeRegs(2), .PipeConfig(fpnew_pkg::DISTRIBUTED), .TagWidth(4),
    .AuxWidth(3), .WatchdogCycles(8)) dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv2), .in_ready_o(ir2), .tag_i(ti2), .aux_i(ai2),
    .flush_i(fl2), .out_valid_o(ov2), .out_ready_i(or2), .tag_o(to2), .aux_o(ao2),
    .busy_o(busy2), .reg_enable_o(re2), .fsm_start_o(st2), .fsm_ready_i(fr2), .error_o(err2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    iv0 = 1; fr0_m = 1; iv2 = 1; fr2_m = 1;
    tick(); tick();
    #1;
    n_vec++; if ({st0, ov0, busy0, err0, re0} !== 5'b0) begin n_err++; $display("FAIL reset_d0 got=%b exp=00000", {st0, ov0, busy0, err0, re0}); end
    n_vec++; if ({st2, ov2, busy2, err2, re2} !== 6'b0) begin n_err++; $display("FAIL reset_d2 got=%b exp=000000", {st2, ov2, busy2, err2, re2}); end
    iv0 = 0; iv2 = 0; rst = 0;
    tick();
    #1;
    n_vec++; if (busy0 !== 1'b0 || busy2 !== 1'b0) begin n_err++; $display("FAIL reset_idle busy0=%b busy2=%b exp=0", busy0, busy2); end
  endtask

  task automatic test_latency();
    iv0 = 1; ti0 = 5; ai0 = 2; fr0_m = 1; or0 = 0;
    #1;
    n_vec++; if (st0 !== 1'b1 || ir0 !== 1'b1) begin n_err++; $display("FAIL lat_start start=%b ready=%b exp=1,1", st0, ir0); end
    tick();
    iv0 = 0; fr0_m = 0;
    #1;
    n_vec++; if ({st0, ov0, busy0} !== 3'b001) begin n_err++; $display("FAIL lat_arm got=%b exp=001", {st0, ov0, busy0}); end
    for (int k = 0; k < 10; k++) begin
      tick();
      #1;
      n_vec++; if ({st0, ov0, ir0} !== 3'b000) begin n_err++; $display("FAIL lat_busy%0d got=%b exp=000", k, {st0, ov0, ir0}); end
    end
    tick();
    fr0_m = 1;
    #1;
    n_vec++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL lat_ready_cycle out_valid=%b exp=0", ov0); end
    tick();
    n_vec++; if (ov0 !== 1'b1 || to0 !== 4'd5 || ao0 !== 3'd2) begin n_err++; $display("FAIL lat_done valid=%b tag=%0d aux=%0d exp=1,5,2", ov0, to0, ao0); end
    or0 = 1;
    tick();
    or0 = 0;
    #1;
    n_vec++; if (ov0 !== 1'b0 || busy0 !== 1'b0) begin n_err++; $display("FAIL lat_drain valid=%b busy=%b exp=0,0", ov0, busy0); end
  endtask

  task automatic test_stall_done();
    iv0 = 1; ti0 = 7; ai0 = 1; fr0_m = 1; or0 = 0;
    tick();
    iv0 = 0;
    tick(); tick();
    n_vec++; if (ov0 !== 1'b1 || to0 !== 4'd7) begin n_err++; $display("FAIL min_latency valid=%b tag=%0d exp=1,7", ov0, to0); end
    iv0 = 1; ti0 = 9; ai0 = 4;
    for (int k = 0; k < 20; k++) begin
      #1;
      n_vec++; if ({st0, ir0, ov0} !== 3'b001 || to0 !== 4'd7 || ao0 !== 3'd1) begin n_err++; $display("FAIL stall%0d st/ir/ov=%b tag=%0d aux=%0d exp=001,7,1", k, {st0, ir0, ov0}, to0, ao0); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    or0 = 1;
    #1;
    n_vec++; if ({st0, ir0, ov0} !== 3'b111) begin n_err++; $display("FAIL b2b_start got=%b exp=111", {st0, ir0, ov0}); end
    tick();
    iv0 = 0; or0 = 0;
    #1;
    n_vec++; if (ov0 !== 1'b0 || busy0 !== 1'b1) begin n_err++; $display("FAIL b2b_arm valid=%b busy=%b exp=0,1", ov0, busy0); end
    tick(); tick();
    n_vec++; if (ov0 !== 1'b1 || to0 !== 4'd9 || ao0 !== 3'd4) begin n_err++; $display("FAIL b2b_done valid=%b tag=%0d aux=%0d exp=1,9,4", ov0, to0, ao0); end
    or0 = 1;
    tick();
    or0 = 0;
  endtask

  task automatic test_reset_busy();
    iv0 = 1; ti0 = 3; fr0_m = 1;
    tick();
    iv0 = 0; fr0_m = 0;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0; fr0_m = 1;
    #1;
    n_vec++; if ({st0, ov0, busy0, err0} !== 4'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0000", {st0, ov0, busy0, err0}); end
    iv0 = 1; ti0 = 4; ai0 = 6;
    #1;
    n_vec++; if (st0 !== 1'b1) begin n_err++; $display("FAIL rst_restart start=%b exp=1", st0); end
    tick();
    iv0 = 0;
    tick(); tick();
    n_vec++; if (ov0 !== 1'b1 || to0 !== 4'd4 || ao0 !== 3'd6) begin n_err++; $display("FAIL rst_next valid=%b tag=%0d exp=1,4", ov0, to0); end
    or0 = 1;
    tick();
    or0 = 0;
  endtask

  task automatic test_pipe_latency();
    iv2 = 1; ti2 = 11; ai2 = 5; fr2_m = 1; or2 = 1;
    #1;
    n_vec++; if (re2 !== 2'b01 || ir2 !== 1'b1) begin n_err++; $display("FAIL pipe_load reg_en=%b ready=%b exp=01,1", re2, ir2); end
    for (int c = 1; c <= 5; c++) begin
      tick();
      iv2 = 0;
      #1;
      n_vec++; if (ov2 !== (c == 5)) begin n_err++; $display("FAIL pipe_c%0d out_valid=%b exp=%b", c, ov2, c == 5); end
      if (c == 1) begin n_vec++; if (st2 !== 1'b1) begin n_err++; $display("FAIL pipe_start got=%b exp=1", st2); end end
      if (c == 4) begin n_vec++; if (re2 !== 2'b10) begin n_err++; $display("FAIL pipe_outload reg_en=%b exp=10", re2); end end
    end
    n_vec++; if (to2 !== 4'd11 || ao2 !== 3'd5) begin n_err++; $display("FAIL pipe_tag tag=%0d aux=%0d exp=11,5", to2, ao2); end
    tick();
    or2 = 0;
  endtask

  task automatic test_flush();
    iv2 = 1; ti2 = 13; fr2_m = 1;
    tick();
    iv2 = 0;
    tick();
    fr2_m = 0;
    tick();
    fl2 = 1; iv2 = 1; ti2 = 2;
    #1;
    n_vec++; if (st2 !== 1'b0 || re2 !== 2'b00) begin n_err++; $display("FAIL flush_gate start=%b reg_en=%b exp=0,00", st2, re2); end
    tick();
    fl2 = 0; iv2 = 0; fr2_m = 1; or2 = 1;
    #1;
    n_vec++; if (busy2 !== 1'b0 || ov2 !== 1'b0) begin n_err++; $display("FAIL flush_busy busy=%b valid=%b exp=0,0", busy2, ov2); end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_vec++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL flush_ghost%0d out_valid=%b exp=0", k, ov2); end
    end
    or2 = 0;
  endtask

  task automatic test_watchdog();
    iv2 = 1; ti2 = 6; fr2_m = 1; or2 = 0;
    tick();
    iv2 = 0;
    tick();
    fr2_m = 0;
    tick();
    for (int k = 1; k <= 8; k++) begin
      #1;
      n_vec++; if (err2 !== (WD_EN && k == 8)) begin n_err++; $display("FAIL wd_cycle%0d error=%b exp=%b", k, err2, WD_EN && k == 8); end
      n_vec++; if (err0 !== 1'b0) begin n_err++; $display("FAIL wd_d0 error=%b exp=0", err0); end
      tick();
    end
    n_vec++; if (busy2 !== !WD_EN || err2 !== 1'b0) begin n_err++; $display("FAIL wd_after busy=%b error=%b exp=%b,0", busy2, err2, !WD_EN); end
    fr2_m = 1; or2 = 1;
    tick(); tick(); tick();
    n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL wd_drain busy=%b exp=0", busy2); end
    or2 = 0;
  endtask

  task automatic test_random();
    logic [6:0] q0[$], q2[$];
    logic [6:0] last0 = 0, last2 = 0;
    logic held0 = 0, held2 = 0;
    u_mode = 1;
    for (int cyc = 0; cyc < 1700; cyc++) begin
      if (cyc < 1500) begin
        iv0 = $urandom_range(0, 1); ti0 = 4'($urandom); ai0 = 3'($urandom);
        iv2 = $urandom_range(0, 1); ti2 = 4'($urandom); ai2 = 3'($urandom);
        or0 = $urandom_range(0, 3) != 0; or2 = $urandom_range(0, 3) != 0;
      end else begin
        iv0 = 0; iv2 = 0; or0 = 1; or2 = 1;
      end
      #1;
      if (iv0 && ir0) q0.push_back({ti0, ai0});
      if (iv2 && ir2) q2.push_back({ti2, ai2});
      if (held0) begin n_vec++; if (ov0 !== 1'b1 || {to0, ao0} !== last0) begin n_err++; $display("FAIL rnd_hold0 valid=%b data=%h exp=1,%h", ov0, {to0, ao0}, last0); end end
      if (held2) begin n_vec++; if (ov2 !== 1'b1 || {to2, ao2} !== last2) begin n_err++; $display("FAIL rnd_hold2 valid=%b data=%h exp=1,%h", ov2, {to2, ao2}, last2); end end
      if (ov0 && or0) begin
        n_vec++;
        if (q0.size() == 0) begin n_err++; $display("FAIL rnd_out0 data=%h exp=none", {to0, ao0}); end
        else begin if ({to0, ao0} !== q0[0]) begin n_err++; $display("FAIL rnd_out0 data=%h exp=%h", {to0, ao0}, q0[0]); end void'(q0.pop_front()); end
      end
      if (ov2 && or2) begin
        n_vec++;
        if (q2.size() == 0) begin n_err++; $display("FAIL rnd_out2 data=%h exp=none", {to2, ao2}); end
        else begin if ({to2, ao2} !== q2[0]) begin n_err++; $display("FAIL rnd_out2 data=%h exp=%h", {to2, ao2}, q2[0]); end void'(q2.pop_front()); end
      end
      if (err0 || err2) begin n_vec++; n_err++; $display("FAIL rnd_error err0=%b err2=%b exp=0,0", err0, err2); end
      held0 = ov0 && !or0; last0 = {to0, ao0};
      held2 = ov2 && !or2; last2 = {to2, ao2};
      tick();
    end
    n_vec++; if (q0.size() != 0 || q2.size() != 0) begin n_err++; $display("FAIL rnd_drain pending0=%0d pending2=%0d exp=0,0", q0.size(), q2.size()); end
    n_vec++; if (busy0 !== 1'b0 || busy2 !== 1'b0) begin n_err++; $display("FAIL rnd_idle busy0=%b busy2=%b exp=0,0", busy0, busy2); end
    u_mode = 0; or0 = 0; or2 = 0;
  endtask

  initial begin
    #1;
    test_reset();
    test_latency();
    test_stall_done();
    test_back_to_back();
    test_reset_busy();
    test_pipe_latency();
    test_flush();
    test_watchdog();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/fpnew_divsqrt_multi_ctrl.md
FPNEW_DIVSQRT_MULTI_CTRL -- requirements
Module: fpnew_divsqrt_multi_ctrl

Interface
REQ-001 Parameter NumPipeRegs, default 0: total external pipeline register stages.
REQ-002 Parameter PipeConfig, default fpnew_pkg::AFTER: split of stages into input and output stages (BEFORE / AFTER / INSIDE / DISTRIBUTED).
REQ-003 Parameter TagWidth, default 1: width of the opaque tag field.
REQ-004 Parameter AuxWidth, default 1: width of the opaque aux field.
REQ-005 Parameter WatchdogCycles, default 64: BUSY-state timeout.
REQ-006 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-007 Port clk_i, in, 1: clock.
REQ-008 Port rst_i, in, 1: synchronous active-high reset.
REQ-009 Port in_valid_i / in_ready_o, in/out, 1: upstream handshake.
REQ-010 Port tag_i / aux_i, in, TagWidth / AuxWidth: tag and aux for each operation.
REQ-011 Port flush_i, in, 1: kill all in-flight operations.
REQ-012 Port out_valid_o / out_ready_i, out/in, 1: downstream handshake.
REQ-013 Port tag_o / aux_o, out, TagWidth / AuxWidth: tag and aux of the result.
REQ-014 Port busy_o, out, 1: any operation in flight.
REQ-015 Port reg_enable_o, out, NumPipeRegs: per-stage enables to the datapath.
REQ-016 Port fsm_start_o, out, 1: issue to the iterative unit.
REQ-017 Port fsm_ready_i, in, 1: the unit is idle.
REQ-018 Port error_o, out, 1: watchdog timeout pulse.

Function
REQ-019 NUM_INP_REGS and NUM_OUT_REGS SHALL be derived from NumPipeRegs and PipeConfig:
- BEFORE: all stages are input stages.
- AFTER and INSIDE: all stages are output stages.
- DISTRIBUTED: NumPipeRegs/2 input stages and (NumPipeRegs+1)/2 output stages.
REQ-020 Input and output stages SHALL be valid/ready stages carrying tag and aux; each stage advances when its input is valid and the stage is empty or draining.
REQ-021 reg_enable_o[i] SHALL be high exactly when stage i loads; output stage j uses index NUM_INP_REGS+j.
REQ-022 The FSM SHALL have the states IDLE, ARM, BUSY and DONE.
REQ-023 fsm_start_o SHALL be high when all of the following hold:
- the last input stage is valid;
- fsm_ready_i is high;
- state is IDLE, or state is DONE and output stage 0 loads in the same cycle.
REQ-024 On start, the FSM SHALL consume the input stage, capture tag and aux, and go to ARM.
REQ-025 ARM SHALL last exactly 1 cycle with fsm_ready_i ignored, then go to BUSY.
REQ-026 BUSY SHALL go to DONE in the first cycle fsm_ready_i=1.
REQ-027 DONE SHALL present valid to output stage 0 and return to IDLE when stage 0 loads, unless a new start occurs in the same cycle.
REQ-028 With NUM_OUT_REGS=0, out_valid_o SHALL equal (state==DONE), and the DONE exit SHALL be on out_ready_i.
REQ-029 in_ready_o SHALL be the ready of input stage 0; with NUM_INP_REGS=0, in_ready_o SHALL equal the start condition without the valid term.
REQ-030 flush_i SHALL, in the same edge, clear all stage valids, force IDLE, and suppress fsm_start_o and reg_enable_o.
REQ-031 flush_i SHALL take priority over a simultaneous start or output handshake.
REQ-032 busy_o SHALL be high when any stage is valid or state != IDLE.
REQ-033 out_valid_o SHALL be held with stable tag_o and aux_o until out_ready_i.
REQ-034 Minimum latency SHALL be 3 cycles + unit time + NUM_INP_REGS + NUM_OUT_REGS from input acceptance to out_valid_o.

Reset
REQ-035 rst_i SHALL set state IDLE, clear all valids and the watchdog count, and hold fsm_start_o, out_valid_o, error_o, reg_enable_o and busy_o at 0.
REQ-036 rst_i during BUSY SHALL abandon the operation silently; no output is produced.

Configuration
REQ-037 With FPNEW_DIVSQRT_CTRL_WATCHDOG_EN defined:
- a counter SHALL clear on entry to BUSY and count BUSY cycles;
- at WatchdogCycles it SHALL pulse error_o for 1 cycle, force IDLE and drop the operation.
REQ-038 Without FPNEW_DIVSQRT_CTRL_WATCHDOG_EN, error_o SHALL be tied to 0 and no counter SHALL exist.

Structure
REQ-039 The FSM state enum and the NUM_INP_REGS / NUM_OUT_REGS derivation functions SHALL live in fpnew_pkg.
REQ-040 One sub-module, fpnew_divsqrt_ctrl_stage (a single valid/ready stage with tag and aux), SHALL be instantiated per pipeline stage.

Verification
REQ-041 NumPipeRegs=0: accept tag 5; fsm_ready_i low for 10 cycles after ARM -> fsm_start_o=1 once; out_valid_o with tag_o=5 in the cycle after fsm_ready_i returns.
REQ-042 out_ready_i held 0 for 20 cycles while in DONE, new input waiting -> no second start; in_ready_o=0; tag_o stable.
REQ-043 DONE with out_ready_i=1 and a new valid input in the same cycle -> back-to-back start; no idle cycle.
REQ-044 flush_i asserted in BUSY with NumPipeRegs=2 (DISTRIBUTED) -> the next cycle shows busy_o=0 and no out_valid_o for that tag.
REQ-045 Watchdog enabled, WatchdogCycles=8, fsm_ready_i stuck 0 -> error_o pulses in BUSY cycle 8, then IDLE; not compiled in -> error_o never 1.
REQ-046 rst_i asserted mid-BUSY -> all outputs are 0 the next cycle; the next operation completes normally.
